// File: rtl/alu_multicycle.sv
// ============================================================================
//  Module   : alu_multicycle
//  Brief    : RV-style ALU, single-cycle ops plus an iterative shift-add MUL.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_multicycle #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      ALUOp_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int N   = XLEN / MUL_STEP;
  localparam int CW  = $clog2(N + 1);
  localparam int SHW = $clog2(XLEN);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
  } op_t;

  state_t          r_state;
  state_t          w_state_nxt;
  op_t             w_op;
  logic            w_accept;
  logic            w_last;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu_res;
  logic [XLEN-1:0] w_partial;
  logic [XLEN-1:0] w_acc_nxt;

  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_valid;
  logic            r_illegal;
  logic            r_zero;
  logic [XLEN-1:0] r_result;

  assign ready_o   = (r_state == S_IDLE);
  assign busy_o    = (r_state == S_MUL);
  assign valid_o   = r_valid;
  assign illegal_o = r_illegal;
  assign zero_o    = r_zero;
  assign result_o  = r_result;

  assign w_accept = valid_i && ready_o;
  assign w_shamt  = src2_i[SHW-1:0];
  assign w_last   = (r_cnt == C_LAST);

  always_comb begin
    w_op = OP_ILL;
    case (ALUOp_i)
      2'b00: w_op = OP_ADD;
      2'b01: w_op = OP_SUB;
      2'b10: begin
        case (funct_i)
          10'b0000000111: w_op = OP_AND;
          10'b0000000100: w_op = OP_XOR;
          10'b0000000001: w_op = OP_SLL;
          10'b0000000000: w_op = OP_ADD;
          10'b0100000000: w_op = OP_SUB;
          10'b0000001000: w_op = OP_MUL;
          default:        w_op = OP_ILL;
        endcase
      end
      default: begin
        case (funct_i[2:0])
          3'b000:  w_op = OP_ADD;
          3'b101:  w_op = funct_i[8] ? OP_SRA : OP_SRL;
          default: w_op = OP_ILL;
        endcase
      end
    endcase
  end

  // Illegal ops fall through to zero so zero_o reports them as a zero result.
  always_comb begin
    w_alu_res = '0;
    case (w_op)
      OP_ADD:  w_alu_res = src1_i + src2_i;
      OP_SUB:  w_alu_res = src1_i - src2_i;
      OP_AND:  w_alu_res = src1_i & src2_i;
      OP_XOR:  w_alu_res = src1_i ^ src2_i;
      OP_SLL:  w_alu_res = src1_i << w_shamt;
      OP_SRL:  w_alu_res = src1_i >> w_shamt;
      OP_SRA:  w_alu_res = $unsigned($signed(src1_i) >>> w_shamt);
      default: w_alu_res = '0;
    endcase
  end

  always_comb begin
    w_partial = '0;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (r_mplier[k]) begin
        w_partial = w_partial + (r_mcand << k);
      end
    end
    w_acc_nxt = r_acc + w_partial;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && (w_op == OP_MUL)) w_state_nxt = S_MUL;
      S_MUL:  if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_zero    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_op == OP_MUL) begin
              r_mcand  <= src1_i;
              r_mplier <= src2_i;
              r_acc    <= '0;
              r_cnt    <= '0;
            end else begin
              r_valid   <= 1'b1;
              r_illegal <= (w_op == OP_ILL);
              r_result  <= w_alu_res;
              r_zero    <= (w_alu_res == '0);
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << MUL_STEP;
          r_mplier <= r_mplier >> MUL_STEP;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_valid  <= 1'b1;
            r_result <= w_acc_nxt;
            r_zero   <= (w_acc_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// ============================================================================
//  Module   : tb_alu_multicycle
//  Brief    : Randomized self-checking bench for alu_multicycle (STEP 1 and 4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        valid4_i;
  logic [1:0]  aluop;
  logic [9:0]  funct;
  logic [31:0] src1;
  logic [31:0] src2;

  logic        ready_o, valid_o, zero_o, illegal_o, busy_o;
  logic [31:0] result_o;
  logic        ready4_o, valid4_o, zero4_o, illegal4_o, busy4_o;
  logic [31:0] result4_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [9:0] R_FN [6] = '{10'b0000000111, 10'b0000000100, 10'b0000000001,
                                      10'b0000000000, 10'b0100000000, 10'b0000001000};

  always #5 clk = ~clk;

  alu_multicycle #(.XLEN(32), .MUL_STEP(1)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(aluop), .funct_i(funct), .src1_i(src1), .src2_i(src2),
    .valid_o(valid_o), .result_o(result_o), .zero_o(zero_o),
    .illegal_o(illegal_o), .busy_o(busy_o)
  );

  alu_multicycle #(.XLEN(32), .MUL_STEP(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid4_i), .ready_o(ready4_o),
    .ALUOp_i(aluop), .funct_i(funct), .src1_i(src1), .src2_i(src2),
    .valid_o(valid4_o), .result_o(result4_o), .zero_o(zero4_o),
    .illegal_o(illegal4_o), .busy_o(busy4_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [9:0] fn,
                                          input logic [31:0] a, input logic [31:0] b,
                                          output bit ill, output bit is_mul);
    logic [31:0] r;
    r = 32'd0;
    ill = 1'b0;
    is_mul = 1'b0;
    case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: begin
        case (fn)
          10'b0000000111: r = a & b;
          10'b0000000100: r = a ^ b;
          10'b0000000001: r = a << b[4:0];
          10'b0000000000: r = a + b;
          10'b0100000000: r = a - b;
          10'b0000001000: begin r = a * b; is_mul = 1'b1; end
          default: ill = 1'b1;
        endcase
      end
      default: begin
        if (fn[2:0] == 3'b000) r = a + b;
        else if (fn[2:0] == 3'b101) r = fn[8] ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
        else ill = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Issue one op to the selected DUT (must be ready) and check its completion.
  task automatic do_op(input bit sel, input logic [1:0] op, input logic [9:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    bit ill, mul;
    int lat, exp_lat;
    exp = ref_alu(op, fn, a, b, ill, mul);
    exp_lat = mul ? (sel ? 9 : 33) : 1;
    aluop = op; funct = fn; src1 = a; src2 = b;
    if (sel) valid4_i = 1'b1; else valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; valid4_i = 1'b0;
    lat = 1;
    while (!(sel ? valid4_o : valid_o) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, sel ? result4_o : result_o, exp);
    check({tag, ".zero"}, 32'(sel ? zero4_o : zero_o), 32'(exp == 32'd0));
    check({tag, ".illegal"}, 32'(sel ? illegal4_o : illegal_o), 32'(ill));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nbusy, nready, nvalid;
    logic [1:0] op;
    logic [9:0] fn;
    rst = 1'b1; valid_i = 1'b0; valid4_i = 1'b0;
    aluop = 2'd0; funct = 10'd0; src1 = 32'd0; src2 = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    check("rst.valid", 32'(valid_o), 32'd0);
    check("rst.result", result_o, 32'd0);
    check("rst.zero", 32'(zero_o), 32'd0);
    check("rst.illegal", 32'(illegal_o), 32'd0);
    check("rst.busy", 32'(busy_o), 32'd0);
    check("rst.ready", 32'(ready_o), 32'd1);
    rst = 1'b0;

    do_op(0, 2'b10, 10'b0000000000, 32'd5, 32'd7, "r_add");
    do_op(0, 2'b10, 10'b0100000000, 32'd7, 32'd7, "r_sub");
    do_op(0, 2'b01, 10'h3FF, 32'd3, 32'd3, "br_sub");
    do_op(0, 2'b11, 10'b0100000101, 32'h8000_0000, 32'd4, "srai");
    do_op(0, 2'b11, 10'b0000000101, 32'h8000_0000, 32'd4, "srli");
    do_op(0, 2'b10, 10'b0000000001, 32'd1, 32'd33, "sll");
    do_op(0, 2'b10, 10'b0000000010, 32'd9, 32'd4, "r_illegal");
    do_op(0, 2'b11, 10'b0000000001, 32'd9, 32'd4, "i_illegal");

    // Long multiply with stray requests and operand churn while busy.
    aluop = 2'b10; funct = 10'b0000001000; src1 = 32'hFFFF_FFFF; src2 = 32'd3;
    valid_i = 1'b1;
    @(posedge clk); #1;
    nbusy = 0; nready = 0; nvalid = 0;
    for (int k = 1; k <= 32; k++) begin
      if (busy_o) nbusy++;
      if (ready_o) nready++;
      if (valid_o) nvalid++;
      valid_i = 1'($urandom_range(0, 1));
      aluop = 2'($urandom_range(0, 3));
      src1 = $urandom; src2 = $urandom;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    check("mul.busy_cycles", 32'(nbusy), 32'd32);
    check("mul.ready_high_cycles", 32'(nready), 32'd0);
    check("mul.early_valid", 32'(nvalid), 32'd0);
    check("mul.valid_at_33", 32'(valid_o), 32'd1);
    check("mul.result", result_o, 32'hFFFF_FFFD);
    check("mul.ready_at_done", 32'(ready_o), 32'd1);

    do_op(0, 2'b10, 10'b0000001000, 32'd6, 32'd7, "b2b_mul");
    do_op(0, 2'b00, 10'h155, 32'd100, 32'd23, "b2b_add");
    do_op(1, 2'b10, 10'b0000001000, 32'd6, 32'd7, "mul4");

    // Reset in the tenth multiply cycle.
    aluop = 2'b10; funct = 10'b0000001000; src1 = 32'd11; src2 = 32'd13;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mulrst.busy", 32'(busy_o), 32'd0);
    check("mulrst.ready", 32'(ready_o), 32'd1);
    check("mulrst.result", result_o, 32'd0);
    nvalid = 0;
    repeat (40) begin
      if (valid_o) nvalid++;
      @(posedge clk); #1;
    end
    check("mulrst.no_valid", 32'(nvalid), 32'd0);

    // Reset beats a simultaneous request.
    rst = 1'b1; valid_i = 1'b1; aluop = 2'b00; src1 = 32'd5; src2 = 32'd5;
    @(posedge clk); #1;
    rst = 1'b0; valid_i = 1'b0;
    @(posedge clk); #1;
    check("rstpri.valid", 32'(valid_o), 32'd0);
    check("rstpri.result", result_o, 32'd0);

    do_op(0, 2'b00, 10'd0, 32'd1, 32'd1, "post_rst_add");

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b10) begin
        int s;
        s = $urandom_range(0, 7);
        fn = (s < 6) ? R_FN[s] : 10'($urandom);
      end else begin
        fn = 10'($urandom);
        case ($urandom_range(0, 2))
          0: fn[2:0] = 3'b000;
          1: fn[2:0] = 3'b101;
          default: ;
        endcase
      end
      do_op(0, op, fn, $urandom, $urandom, "rand");
    end

    for (int i = 0; i < 20; i++) begin
      do_op(1, 2'b10, 10'b0000001000, $urandom, $urandom, "rand_mul4");
    end

    do_op(0, 2'b00, 10'd0, 32'd9, 32'd1, "hold_add");
    @(posedge clk); #1;
    check("hold.valid", 32'(valid_o), 32'd0);
    check("hold.illegal", 32'(illegal_o), 32'd0);
    check("hold.result", result_o, 32'd10);
    check("hold.zero", 32'(zero_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (power of 2, 8..64).
REQ-002 SHALL have parameter MUL_STEP, default 1, multiplier bits retired per cycle (power of 2, divides XLEN).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port valid_i  input  1  operation request.
REQ-006 SHALL have port ready_o  output  1  request is accepted this cycle when valid_i && ready_o.
REQ-007 SHALL have port ALUOp_i  input  2  op class: 2'b00 load/store (ADD), 2'b01 branch (SUB), 2'b10 R-type, 2'b11 I-type.
REQ-008 SHALL have port funct_i  input  10  {funct7, funct3}; I-type uses funct3 = funct_i[2:0] and funct_i[8] (instr bit 30).
REQ-009 SHALL have port src1_i  input  XLEN  operand A.
REQ-010 SHALL have port src2_i  input  XLEN  operand B / immediate.
REQ-011 SHALL have port valid_o  output  1  one-cycle result strobe.
REQ-012 SHALL have port result_o  output  XLEN  result, held stable until the next valid_o.
REQ-013 SHALL have port zero_o  output  1  result_o == 0, qualified by valid_o.
REQ-014 SHALL have port illegal_o  output  1  undecodable op, qualified by valid_o.
REQ-015 SHALL have port busy_o  output  1  multiply in progress (hazard-unit stall).

Function
REQ-016 SHALL decode R-type funct_i: 10'b0000000111 AND, 10'b0000000100 XOR, 10'b0000000001 SLL, 10'b0000000000 ADD, 10'b0100000000 SUB, 10'b0000001000 MUL.
REQ-017 SHALL decode I-type funct3: 000 ADDI; 101 with funct_i[8]=1 SRAI, funct_i[8]=0 SRLI; other funct3 illegal.
REQ-018 SHALL ignore funct_i for ALUOp 00 (ADD) and 01 (SUB).
REQ-019 SHALL take shift amount from src2_i[log2(XLEN)-1:0]; SRAI sign-fills, SRLI/SLL zero-fill.
REQ-020 SHALL compute ADD/SUB/MUL modulo 2^XLEN; MUL returns the low XLEN bits of the product (signedness irrelevant).
REQ-021 SHALL use FSM states IDLE and MUL; ready_o = 1 only in IDLE; busy_o = 1 only in MUL.
REQ-022 SHALL, for a non-MUL op accepted at edge E, register the result and assert valid_o for exactly the cycle after E (latency 1), remaining in IDLE.
REQ-023 SHALL, for MUL accepted at edge E, latch operands, enter MUL, run N = XLEN/MUL_STEP shift-add iterations on the next N edges, return to IDLE on the Nth, and assert valid_o in the cycle after it (latency N+1 edges from E).
REQ-024 SHALL keep an iteration counter of ceil(log2(N+1)) bits, cleared on acceptance; MUL exits when it reaches N-1 at an iteration edge.
REQ-025 SHALL ignore valid_i while in MUL; operands and funct_i changes during MUL do not affect the result.
REQ-026 SHALL accept a new op in the same cycle valid_o for a MUL is high (ready_o = 1 in that cycle), allowing back-to-back issue.
REQ-027 SHALL, for an illegal op (undefined R-type funct, illegal I-type funct3), produce result_o = 0, illegal_o = 1, zero_o = 1, at latency 1, without entering MUL.
REQ-028 SHALL keep valid_o, illegal_o low in cycles without a completing op; result_o and zero_o hold the last values.
REQ-029 SHALL contain no latches; every decode path assigns every internal control signal.

Reset
REQ-030 SHALL, when rst_i is sampled high, go to IDLE and clear valid_o, illegal_o, busy_o, result_o, zero_o, and the counter; ready_o = 1 in the following cycle.
REQ-031 SHALL, on reset during MUL, abort the multiply with no valid_o for it.
REQ-032 SHALL give rst_i priority over a simultaneous valid_i; that request is dropped.

Verification
REQ-033 SHALL cover ALU ops: R ADD 5+7 -> valid_o next cycle, result 12, zero_o 0; R SUB 7-7 -> 0, zero_o 1; ALUOp 01 with funct_i = 10'h3FF, 3-3 -> 0, zero_o 1.
REQ-034 SHALL cover shifts: SRAI 0x80000000 by 4 -> 0xF8000000; SRLI same -> 0x08000000; SLL 1 by 33 (src2 = 33) -> 0x00000002.
REQ-035 SHALL cover MUL at XLEN=32, MUL_STEP=1: 0xFFFFFFFF*3 -> 0xFFFFFFFD exactly 33 edges after acceptance; busy_o high for 32 cycles; ready_o low throughout; valid_i pulses meanwhile ignored.
REQ-036 SHALL cover back-to-back: MUL 6*7 then ADD issued in the MUL's valid_o cycle -> 42 then ADD result on the next cycle; MUL_STEP=4 -> MUL latency 9.
REQ-037 SHALL cover illegal: R-type funct_i = 10'b0000000010 -> result 0, illegal_o 1, zero_o 1, latency 1.
REQ-038 SHALL cover reset in MUL cycle 10 -> no valid_o, busy_o 0 and ready_o 1 next cycle; a new ADD 1+1 then -> 2.
